// File: rtl/uart_tx_frame.sv
// Parametrised UART serialiser: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits.
// Words are taken through a valid/ready handshake, and every output comes straight from a flop.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_INV       = (PARITY_MODE == 2);
  localparam logic             PAR_EN        = (PARITY_MODE != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT out of range 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS out of range 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc;
  logic                 bit_end;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic acc);
    return acc ^ PAR_INV;
  endfunction

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_acc  <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (state == S_IDLE || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift    <= i_data;
            par_acc  <= 1'b0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_ready <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx      <= shift[0];
            par_acc <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end

        // The shift register presents the next data bit at shift[0]; parity accumulates as bits leave.
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST_DATA) begin
              bit_idx <= '0;
              if (PAR_EN) begin
                tx    <= parity_bit(par_acc);
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[0];
              par_acc <= par_acc ^ shift[0];
              shift   <= shift >> 1;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (bit_idx == IDX_LAST_STOP) begin
              bit_idx  <= '0;
              tx_busy  <= 1'b0;
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
              state    <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
